pueo_trig_source_arbiter: RTL and testbench
===========================================

// Module: pueo_trig_source_arbiter
// PURPOSE
//  Merges trigger requests from NSRC sources (RF, soft, PPS, ext GPI) into one AXI4-S trigger stream feeding
//  the master trigger process. Each source has a 1-deep pending latch with its timestamp; grants are round-robin,
//  issued only on the sysclk_phase_i slot, and followed by a programmable holdoff (deadtime) window.
// PARAMETERS
//  NSRC       4   number of trigger sources (index order per package constants)
//  TIME_W     32  timestamp width (cur_time domain)
//  HOLDOFF_W  16  holdoff counter width, sysclk cycles
// PORTS
//  sysclk_i        in   1            system clock; all logic in this domain
//  sysrst_n_i      in   1            asynchronous active-low reset
//  sysclk_phase_i  in   1            slot strobe; 1 cycle high in every 4
//  runrst_i        in   1            synchronous run reset
//  src_en_i        in   NSRC         per-source enable
//  src_req_i       in   NSRC         per-source request pulse (1 cycle)
//  src_time_i      in   NSRC*TIME_W  timestamp per source, sampled with its req
//  holdoff_i       in   HOLDOFF_W    deadtime after each accepted trigger
//  trig_tdata_o    out  TIME_W       timestamp of issued trigger
//  trig_tuser_o    out  NSRC         source bitmask of issued trigger
//  trig_tvalid_o   out  1            AXI4-S valid
//  trig_tready_i   in   1            AXI4-S ready
//  busy_o          out  1            high in ISSUE or HOLDOFF
//  drop_count_o    out  16           saturating count of dropped requests
// BEHAVIOUR
//  - Reset (sysrst_n_i low): state IDLE, pending=0, rr_ptr=0, all outputs 0.
//  - Request capture: req on enabled source with pending clear -> pending set, time latched, next cycle.
//    Disabled-source reqs ignored, not counted. Clearing src_en_i clears that source's pending next cycle.
//  - Drops (drop_count_o +1, saturates at 0xFFFF; multiple drops same cycle add popcount, still saturate):
//    req while that source already pending; req during HOLDOFF; req on source granted in the same cycle.
//  - FSM IDLE -> ISSUE: in a cycle with sysclk_phase_i=1 and any pending&src_en_i, grant lowest index >= rr_ptr
//    (wrapping). Next cycle: tvalid=1, tdata=granted time, tuser=onehot(grant); granted pending cleared;
//    rr_ptr=grant+1 mod NSRC. Min latency req->tvalid: 2 cycles if phase coincides with pending visibility.
//  - ISSUE: tdata/tuser/tvalid held stable until tvalid&tready; on that cycle -> HOLDOFF, counter=holdoff_i.
//    Pending latches keep accepting reqs during ISSUE.
//  - HOLDOFF: decrement each cycle; at 0 -> IDLE. holdoff_i=0 -> one HOLDOFF cycle then IDLE.
//    holdoff_i sampled only at HOLDOFF entry.
//  - Phase gating: no grant when sysclk_phase_i=0; pending waits for next slot.
//  - runrst_i (any state, highest priority after async reset): pending, rr_ptr, drop_count, counter cleared;
//    tvalid dropped same edge; -> IDLE. Reqs in the runrst_i cycle discarded, not counted.
// CONFIGURATION
//  TRIG_COINCIDENCE_EN defined: grant consumes ALL pending enabled sources; tuser = their mask, tdata = time of the
//    round-robin winner; rr_ptr advances past winner only; no drop for co-pending sources.
//  Undefined: one source per issuance, tuser strictly onehot; other pendings remain for later slots.
// STRUCTURE
//  Package pueo_trig_arb_pkg: state enum {IDLE,ISSUE,HOLDOFF}; SRC_RF=0, SRC_SOFT=1, SRC_PPS=2, SRC_EXT=3;
//    DROP_W=16 and saturating-add function.
//  Sub-module pueo_rr_arbiter: combinational round-robin grant from (req vector, ptr) -> onehot grant + index.
//  Top holds pending/time regs, FSM, holdoff counter, drop counter, output regs.
// TESTING
//  1. Reset/idle: sysrst_n_i low then high, no reqs -> tvalid=0, busy_o=0, drop_count_o=0 for 100 cycles.
//  2. Single RF req time=0x1234, tready=1, holdoff=20 -> one beat tdata=0x1234, tuser=0001 on first slot;
//     busy_o high 21+ cycles; second RF req at holdoff cycle 5 -> drop_count_o=1.
//  3. RF,SOFT,PPS req same cycle, tready=1, holdoff=0 -> beats tuser 0001,0010,0100 on successive slots
//     (without TRIG_COINCIDENCE_EN); with it -> single beat tuser=0111, tdata=RF time.
//  4. Backpressure: tready=0 for 30 cycles -> tdata/tuser/tvalid stable; SOFT req during ISSUE pends,
//     issued after holdoff; repeated SOFT req while pending -> drop_count_o +1.
//  5. runrst_i mid-ISSUE with 2 pendings -> tvalid=0 next edge, drop_count_o=0, no beats until new reqs;
//     next grant starts at rr_ptr=0.
//  6. Disable EXT while pending, phase-gating check: req just after slot -> tvalid exactly after next slot;
//     EXT never issued; force 70000 drops -> drop_count_o=0xFFFF.

Source files
------------

// File: rtl/pueo_trig_arb_pkg.sv
// Shared types and helpers for the PUEO trigger source arbiter.
// Holds the FSM state encoding, the source index map, the drop counter
// width and the saturating adder used by the drop counter.
package pueo_trig_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    HOLDOFF = 2'd2
  } arb_state_t;

  // Source index map (bit position in src_* vectors and in tuser)
  localparam int unsigned SRC_RF   = 0;
  localparam int unsigned SRC_SOFT = 1;
  localparam int unsigned SRC_PPS  = 2;
  localparam int unsigned SRC_EXT  = 3;

  localparam int DROP_W = 16;

  // Add inc to acc, clamping at all-ones instead of wrapping
  function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] acc,
                                                input logic [DROP_W-1:0] inc);
    logic [DROP_W:0] sum;
    sum = {1'b0, acc} + {1'b0, inc};
    if (sum[DROP_W]) begin
      return {DROP_W{1'b1}};
    end else begin
      return sum[DROP_W-1:0];
    end
  endfunction

endpackage

// File: rtl/pueo_rr_arbiter.sv
// Combinational round-robin picker: starting at ptr and wrapping, returns
// the first asserted request as a onehot grant plus its index.
module pueo_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             hit
);

  // Scan N positions from ptr upward; first requester wins
  always_comb begin
    int j;
    grant = {N{1'b0}};
    idx   = {IDX_W{1'b0}};
    hit   = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!hit && req[j]) begin
        hit      = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end else begin
        hit = hit;
      end
    end
  end

endmodule

// File: rtl/pueo_trig_source_arbiter.sv
// PUEO trigger source arbiter.
// Each source owns a one-deep pending latch with its timestamp. Pending
// sources are granted round-robin, only on the sysclk_phase_i slot, and each
// accepted beat is followed by a programmable holdoff window.
// Build option: define TRIG_COINCIDENCE_EN to let one grant consume every
// pending enabled source (tuser carries their mask, tdata the winner's time).
// Without it every beat carries exactly one source.
module pueo_trig_source_arbiter
  import pueo_trig_arb_pkg::*;
#(
  parameter int NSRC      = 4,
  parameter int TIME_W    = 32,
  parameter int HOLDOFF_W = 16
) (
  input  logic                   sysclk_i,
  input  logic                   sysrst_n_i,
  input  logic                   sysclk_phase_i,
  input  logic                   runrst_i,
  input  logic [NSRC-1:0]        src_en_i,
  input  logic [NSRC-1:0]        src_req_i,
  input  logic [NSRC*TIME_W-1:0] src_time_i,
  input  logic [HOLDOFF_W-1:0]   holdoff_i,
  output logic [TIME_W-1:0]      trig_tdata_o,
  output logic [NSRC-1:0]        trig_tuser_o,
  output logic                   trig_tvalid_o,
  input  logic                   trig_tready_i,
  output logic                   busy_o,
  output logic [DROP_W-1:0]      drop_count_o
);

  localparam int PTR_W = (NSRC > 1) ? $clog2(NSRC) : 1;

  arb_state_t           state_r;
  logic [NSRC-1:0]      pending_r;
  logic [TIME_W-1:0]    time_r [NSRC];
  logic [PTR_W-1:0]     rr_ptr_r;
  logic [HOLDOFF_W-1:0] hold_cnt_r;
  logic [DROP_W-1:0]    drop_cnt_r;
  logic [TIME_W-1:0]    tdata_r;
  logic [NSRC-1:0]      tuser_r;
  logic                 tvalid_r;
  logic                 busy_r;

  logic [NSRC-1:0]      arb_req_s;
  logic [NSRC-1:0]      arb_grant_s;
  logic [PTR_W-1:0]     arb_idx_s;
  logic                 arb_hit_s;
  logic                 grant_fire_s;
  logic [NSRC-1:0]      consume_s;
  logic [NSRC-1:0]      req_en_s;
  logic [NSRC-1:0]      capture_s;
  logic [NSRC-1:0]      drop_vec_s;
  logic [DROP_W-1:0]    drop_inc_s;
  logic [PTR_W-1:0]     ptr_next_s;

  assign arb_req_s = pending_r & src_en_i;

  pueo_rr_arbiter #(
    .N     (NSRC),
    .IDX_W (PTR_W)
  ) u_rr (
    .req   (arb_req_s),
    .ptr   (rr_ptr_r),
    .grant (arb_grant_s),
    .idx   (arb_idx_s),
    .hit   (arb_hit_s)
  );

  // Grant decision, capture/drop classification and drop popcount
  always_comb begin
    grant_fire_s = (state_r == IDLE) && sysclk_phase_i && arb_hit_s;
`ifdef TRIG_COINCIDENCE_EN
    consume_s = arb_req_s;
`else
    consume_s = arb_grant_s;
`endif
    req_en_s = src_req_i & src_en_i;
    if (state_r == HOLDOFF) begin
      // Deadtime: every enabled request is lost
      capture_s  = {NSRC{1'b0}};
      drop_vec_s = req_en_s;
    end else begin
      // A source being granted this cycle is still pending, so a new
      // request on it lands in the drop branch as well
      capture_s  = req_en_s & ~pending_r;
      drop_vec_s = req_en_s & pending_r;
    end
    drop_inc_s = {DROP_W{1'b0}};
    for (int i = 0; i < NSRC; i++) begin
      drop_inc_s = drop_inc_s + DROP_W'(drop_vec_s[i]);
    end
    if (arb_idx_s == PTR_W'(NSRC - 1)) begin
      ptr_next_s = {PTR_W{1'b0}};
    end else begin
      ptr_next_s = arb_idx_s + PTR_W'(1);
    end
  end

  // Pending latches and their captured timestamps
  always_ff @(posedge sysclk_i or negedge sysrst_n_i) begin
    if (!sysrst_n_i) begin
      pending_r <= {NSRC{1'b0}};
      for (int i = 0; i < NSRC; i++) begin
        time_r[i] <= {TIME_W{1'b0}};
      end
    end else if (runrst_i) begin
      pending_r <= {NSRC{1'b0}};
    end else begin
      pending_r <= ((pending_r & ~(grant_fire_s ? consume_s : {NSRC{1'b0}})) | capture_s)
                   & src_en_i;
      for (int i = 0; i < NSRC; i++) begin
        if (capture_s[i]) begin
          time_r[i] <= src_time_i[i*TIME_W +: TIME_W];
        end
      end
    end
  end

  // Saturating drop counter
  always_ff @(posedge sysclk_i or negedge sysrst_n_i) begin
    if (!sysrst_n_i) begin
      drop_cnt_r <= {DROP_W{1'b0}};
    end else if (runrst_i) begin
      drop_cnt_r <= {DROP_W{1'b0}};
    end else begin
      drop_cnt_r <= sat_add(drop_cnt_r, drop_inc_s);
    end
  end

  // Issue FSM with registered stream outputs, busy flag and holdoff counter
  always_ff @(posedge sysclk_i or negedge sysrst_n_i) begin
    if (!sysrst_n_i) begin
      state_r    <= IDLE;
      rr_ptr_r   <= {PTR_W{1'b0}};
      hold_cnt_r <= {HOLDOFF_W{1'b0}};
      tdata_r    <= {TIME_W{1'b0}};
      tuser_r    <= {NSRC{1'b0}};
      tvalid_r   <= 1'b0;
      busy_r     <= 1'b0;
    end else if (runrst_i) begin
      state_r    <= IDLE;
      rr_ptr_r   <= {PTR_W{1'b0}};
      hold_cnt_r <= {HOLDOFF_W{1'b0}};
      tdata_r    <= {TIME_W{1'b0}};
      tuser_r    <= {NSRC{1'b0}};
      tvalid_r   <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_fire_s) begin
            state_r  <= ISSUE;
            tdata_r  <= time_r[arb_idx_s];
            tuser_r  <= consume_s;
            tvalid_r <= 1'b1;
            busy_r   <= 1'b1;
            rr_ptr_r <= ptr_next_s;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        ISSUE: begin
          // Beat held stable until the consumer takes it
          if (trig_tready_i) begin
            state_r    <= HOLDOFF;
            tvalid_r   <= 1'b0;
            hold_cnt_r <= holdoff_i;
          end else begin
            state_r <= ISSUE;
          end
        end
        HOLDOFF: begin
          if (hold_cnt_r == {HOLDOFF_W{1'b0}}) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            hold_cnt_r <= hold_cnt_r - HOLDOFF_W'(1);
          end
        end
        default: begin
          state_r  <= IDLE;
          tvalid_r <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  assign trig_tdata_o  = tdata_r;
  assign trig_tuser_o  = tuser_r;
  assign trig_tvalid_o = tvalid_r;
  assign busy_o        = busy_r;
  assign drop_count_o  = drop_cnt_r;

endmodule

// File: tb/tb_pueo_trig_source_arbiter.sv
// Scoreboard bench for pueo_trig_source_arbiter: expected beats are queued
// as requests are driven and compared as the DUT hands them over.
module tb_pueo_trig_source_arbiter;
  import pueo_trig_arb_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  user;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        phase;
  logic        runrst;
  logic [3:0]  src_en;
  logic [3:0]  src_req;
  logic [127:0] src_time;
  logic [15:0] holdoff;
  logic [31:0] tdata;
  logic [3:0]  tuser;
  logic        tvalid;
  logic        tready;
  logic        busy;
  logic [15:0] drop_count;

  int    chk_cnt  = 0;
  int    pass_cnt = 0;
  int    ph       = 0;
  beat_t exp_q[$];
  beat_t mon_exp;

  localparam logic [3:0] M_RF   = 4'(1 << SRC_RF);
  localparam logic [3:0] M_SOFT = 4'(1 << SRC_SOFT);
  localparam logic [3:0] M_PPS  = 4'(1 << SRC_PPS);
  localparam logic [3:0] M_EXT  = 4'(1 << SRC_EXT);

  pueo_trig_source_arbiter dut (
    .sysclk_i       (clk),
    .sysrst_n_i     (rst_n),
    .sysclk_phase_i (phase),
    .runrst_i       (runrst),
    .src_en_i       (src_en),
    .src_req_i      (src_req),
    .src_time_i     (src_time),
    .holdoff_i      (holdoff),
    .trig_tdata_o   (tdata),
    .trig_tuser_o   (tuser),
    .trig_tvalid_o  (tvalid),
    .trig_tready_i  (tready),
    .busy_o         (busy),
    .drop_count_o   (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Advance one cycle; pulses return low and the slot strobe rotates 1-in-4
  task automatic step();
    @(posedge clk);
    #1;
    src_req = 4'd0;
    runrst  = 1'b0;
    ph      = (ph + 1) % 4;
    phase   = (ph == 0);
  endtask

  task automatic set_time(input int s, input logic [31:0] v);
    src_time[s*32 +: 32] = v;
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] u);
    beat_t b;
    b.data = d;
    b.user = u;
    exp_q.push_back(b);
  endtask

  task automatic wait_valid(input int max);
    int n = 0;
    while (!tvalid && n < max) begin
      step();
      n++;
    end
    check_eq("tvalid_seen", 32'(tvalid), 32'd1);
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while ((exp_q.size() != 0 || busy || tvalid) && n < max) begin
      step();
      n++;
    end
    check_eq("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_runrst();
    step();
    runrst = 1'b1;
    step();
  endtask

  task automatic wait_slot();
    int n = 0;
    while (!phase && n < 8) begin
      step();
      n++;
    end
  endtask

  // Transfer monitor: a beat is taken at the edge after a valid&ready cycle
  always @(negedge clk) begin
    if (rst_n && tvalid && tready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_beat", {28'd0, tuser}, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check_eq("beat_tdata", tdata, mon_exp.data);
        check_eq("beat_tuser", {28'd0, tuser}, {28'd0, mon_exp.user});
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0; phase = 1'b0; runrst = 1'b0; src_en = 4'd0; src_req = 4'd0;
    src_time = '0; holdoff = 16'd0; tready = 1'b0;
    repeat (3) step();
    check_eq("rst_tvalid", 32'(tvalid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // 1: idle after reset
    for (int i = 0; i < 100; i++) begin
      step();
      check_eq("idle_tvalid", 32'(tvalid), 32'd0);
      check_eq("idle_busy", 32'(busy), 32'd0);
      check_eq("idle_drop", 32'(drop_count), 32'd0);
    end

    // 2: single RF trigger, holdoff 20, request during holdoff dropped
    src_en = 4'hF; tready = 1'b1; holdoff = 16'd20;
    step();
    src_req = M_RF; set_time(SRC_RF, 32'h1234); push(32'h1234, M_RF);
    wait_valid(12);
    n = 0;
    while (busy && n < 60) begin
      n++;
      step();
      if (n == 5) src_req = M_RF;
    end
    check_eq("busy_len", 32'(n), 32'd22);
    check_eq("holdoff_drop", 32'(drop_count), 32'd1);
    wait_drain(20);

    // 3: three simultaneous sources, round-robin from RF
    do_runrst();
    check_eq("runrst_drop", 32'(drop_count), 32'd0);
    holdoff = 16'd0;
    src_req = M_RF | M_SOFT | M_PPS;
    set_time(SRC_RF, 32'hA0); set_time(SRC_SOFT, 32'hB1); set_time(SRC_PPS, 32'hC2);
`ifdef TRIG_COINCIDENCE_EN
    push(32'hA0, M_RF | M_SOFT | M_PPS);
`else
    push(32'hA0, M_RF); push(32'hB1, M_SOFT); push(32'hC2, M_PPS);
`endif
    wait_drain(60);

    // 4: backpressure hold, SOFT pends during ISSUE, repeat SOFT dropped
    do_runrst();
    holdoff = 16'd3; tready = 1'b0;
    src_req = M_RF; set_time(SRC_RF, 32'h4444); push(32'h4444, M_RF);
    wait_valid(12);
    for (int i = 1; i <= 30; i++) begin
      step();
      if (i == 3) begin
        src_req = M_SOFT; set_time(SRC_SOFT, 32'h5555); push(32'h5555, M_SOFT);
      end
      if (i == 6) begin
        src_req = M_SOFT; set_time(SRC_SOFT, 32'h6666);
      end
      check_eq("bp_tvalid", 32'(tvalid), 32'd1);
      check_eq("bp_tdata", tdata, 32'h4444);
      check_eq("bp_tuser", {28'd0, tuser}, {28'd0, M_RF});
    end
    check_eq("bp_drop", 32'(drop_count), 32'd1);
    tready = 1'b1;
    wait_drain(60);

    // 5: run reset mid-ISSUE with two pendings
    do_runrst();
    holdoff = 16'd0; tready = 1'b0;
    src_req = M_RF; set_time(SRC_RF, 32'h7000);
    wait_valid(12);
    step();
    src_req = M_SOFT | M_PPS; set_time(SRC_SOFT, 32'h7100); set_time(SRC_PPS, 32'h7200);
    step();
    src_req = M_SOFT;
    step();
    check_eq("pre_rr_drop", 32'(drop_count), 32'd1);
    runrst = 1'b1; src_req = M_EXT; set_time(SRC_EXT, 32'h7300);
    step();
    check_eq("rr_tvalid", 32'(tvalid), 32'd0);
    check_eq("rr_drop", 32'(drop_count), 32'd0);
    check_eq("rr_busy", 32'(busy), 32'd0);
    tready = 1'b1;
    repeat (20) step();
    src_req = M_RF | M_PPS; set_time(SRC_RF, 32'h8100); set_time(SRC_PPS, 32'h8300);
`ifdef TRIG_COINCIDENCE_EN
    push(32'h8100, M_RF | M_PPS);
`else
    push(32'h8100, M_RF); push(32'h8300, M_PPS);
`endif
    wait_drain(60);

    // 6a: disabling EXT while pending discards it
    do_runrst();
    wait_slot();
    src_req = M_EXT; set_time(SRC_EXT, 32'hEEEE);
    step();
    src_en = 4'h7;
    step();
    src_en = 4'hF;
    repeat (12) step();

    // 6b: request just after a slot waits for the next slot
    wait_slot();
    step();
    src_req = M_SOFT; set_time(SRC_SOFT, 32'h6060); push(32'h6060, M_SOFT);
    for (int i = 1; i <= 4; i++) begin
      step();
      check_eq("phase_gate", 32'(tvalid), 32'(i == 4));
    end
    wait_drain(20);

    // 6c: drop counter popcount and saturation during a long holdoff
    holdoff = 16'hFFFF;
    src_req = M_RF; set_time(SRC_RF, 32'h9999); push(32'h9999, M_RF);
    wait_valid(12);
    step();
    src_req = 4'hF;
    step();
    src_req = 4'hF;
    step();
    check_eq("drop_popcount", 32'(drop_count), 32'd8);
    for (int i = 0; i < 17498; i++) begin
      src_req = 4'hF;
      step();
    end
    check_eq("drop_saturate", 32'(drop_count), 32'hFFFF);
    do_runrst();
    check_eq("final_drop", 32'(drop_count), 32'd0);
    check_eq("final_busy", 32'(busy), 32'd0);
    check_eq("final_queue", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
